// File: rtl/mem_request_queue_if.sv
// Opcode definitions shared with the trace parser, and the bundle of signals
// between the parser, the request queue and the DRAM scheduler.
package global_defs;
    localparam int unsigned ADDRESS_WIDTH = 32;

    typedef enum logic [1:0] {
        NOP          = 2'd0,
        DATA_READ    = 2'd1,
        DATA_WRITE   = 2'd2,
        OPCODE_FETCH = 2'd3
    } parsed_op_t;
endpackage

interface mem_request_queue_if #(
    parameter int unsigned ADDRESS_WIDTH = global_defs::ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIME_WIDTH    = 64
);
    global_defs::parsed_op_t    in_op;
    logic [ADDRESS_WIDTH-1:0]   in_address;
    logic                       in_ready;
    logic                       out_valid;
    global_defs::parsed_op_t    out_op;
    logic [ADDRESS_WIDTH-1:0]   out_address;
    logic [TIME_WIDTH-1:0]      out_enq_time;
    logic [TIME_WIDTH-1:0]      out_age;
    logic                       out_pop;
    logic [$clog2(DEPTH):0]     occupancy;
    logic                       full;
    logic                       empty;
    logic [TIME_WIDTH-1:0]      cycle_count;

    // Parser and scheduler side drive the operation offer and the pop.
    modport master (
        output in_op, in_address, out_pop,
        input  in_ready, out_valid, out_op, out_address, out_enq_time, out_age,
        input  occupancy, full, empty, cycle_count
    );

    modport slave (
        input  in_op, in_address, out_pop,
        output in_ready, out_valid, out_op, out_address, out_enq_time, out_age,
        output occupancy, full, empty, cycle_count
    );
endinterface

// File: rtl/mem_request_queue.sv
// In-order queue of timestamped parser operations feeding the DRAM scheduler.
// Back-pressures the parser when full; head outputs are forced to NOP/0 when empty.
module mem_request_queue #(
    parameter int unsigned ADDRESS_WIDTH = global_defs::ADDRESS_WIDTH,
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned TIME_WIDTH    = 64
) (
    input  logic                clock,
    input  logic                reset_n,
    mem_request_queue_if.slave  bus
);
    import global_defs::*;

    localparam int unsigned     PTR_W      = $clog2(DEPTH);
    localparam logic [PTR_W:0]  FULL_COUNT = (PTR_W+1)'(DEPTH);

    typedef struct packed {
        parsed_op_t                 op;
        logic [ADDRESS_WIDTH-1:0]   address;
        logic [TIME_WIDTH-1:0]      enq_time;
    } entry_t;

    entry_t                 entries [DEPTH];
    entry_t                 head_entry;
    logic [PTR_W-1:0]       head_ptr;
    logic [PTR_W-1:0]       tail_ptr;
    logic [PTR_W:0]         count;
    logic [TIME_WIDTH-1:0]  cycle_count_r;
    logic                   full_r;
    logic                   empty_r;
    logic                   push;
    logic                   pop;

    // Ready comes from registered occupancy only, so a full queue refuses an
    // offer even in a cycle where the scheduler pops.
    always_comb begin
        full_r  = (count == FULL_COUNT);
        empty_r = (count == '0);
        push    = (bus.in_op != NOP) && !full_r;
        pop     = bus.out_pop && !empty_r;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cycle_count_r <= '0;
            head_ptr      <= '0;
            tail_ptr      <= '0;
            count         <= '0;
        end else begin
            cycle_count_r <= cycle_count_r + TIME_WIDTH'(1);
            if (push) tail_ptr <= tail_ptr + PTR_W'(1);
            if (pop)  head_ptr <= head_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage is left uncleared by reset; occupancy alone decides validity.
    always_ff @(posedge clock) begin
        if (push) begin
            entries[tail_ptr] <= '{op: bus.in_op, address: bus.in_address, enq_time: cycle_count_r};
        end
    end

    always_comb begin
        head_entry       = entries[head_ptr];
        bus.in_ready     = !full_r;
        bus.out_valid    = !empty_r;
        bus.full         = full_r;
        bus.empty        = empty_r;
        bus.occupancy    = count;
        bus.cycle_count  = cycle_count_r;
        bus.out_op       = NOP;
        bus.out_address  = '0;
        bus.out_enq_time = '0;
        bus.out_age      = '0;
        if (!empty_r) begin
            bus.out_op       = head_entry.op;
            bus.out_address  = head_entry.address;
            bus.out_enq_time = head_entry.enq_time;
            bus.out_age      = cycle_count_r - head_entry.enq_time;
        end
    end
endmodule

// File: tb/tb_mem_request_queue.sv
// Directed bench for mem_request_queue: a default-sized instance plus an
// 8-bit-timestamp instance used for the counter wrap scenario.
module tb_mem_request_queue;
    import global_defs::*;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    mem_request_queue_if #(.ADDRESS_WIDTH(32), .DEPTH(16), .TIME_WIDTH(64)) qi ();
    mem_request_queue_if #(.ADDRESS_WIDTH(32), .DEPTH(16), .TIME_WIDTH(8))  wi ();

    mem_request_queue #(.ADDRESS_WIDTH(32), .DEPTH(16), .TIME_WIDTH(64)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (qi)
    );

    mem_request_queue #(.ADDRESS_WIDTH(32), .DEPTH(16), .TIME_WIDTH(8)) dut_w (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (wi)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Reset is released mid-cycle so the next rising edge is the first count.
    task automatic do_reset();
        qi.in_op = NOP; qi.in_address = '0; qi.out_pop = 1'b0;
        wi.in_op = NOP; wi.in_address = '0; wi.out_pop = 1'b0;
        reset_n = 1'b0;
        step();
        #3 reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        checks++; if (qi.empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %0b expected 1", qi.empty); end
        checks++; if (qi.full !== 1'b0) begin errors++; $display("FAIL rst_full: got %0b expected 0", qi.full); end
        checks++; if (qi.in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %0b expected 1", qi.in_ready); end
        checks++; if (qi.out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b expected 0", qi.out_valid); end
        checks++; if (qi.occupancy !== 5'd0) begin errors++; $display("FAIL rst_occupancy: got %0d expected 0", qi.occupancy); end
        checks++; if (qi.out_op !== NOP) begin errors++; $display("FAIL rst_out_op: got %0d expected NOP", qi.out_op); end
        checks++; if (qi.out_age !== 64'd0) begin errors++; $display("FAIL rst_out_age: got %0d expected 0", qi.out_age); end
        do_reset();
        repeat (5) step();
        checks++; if (qi.cycle_count !== 64'd5) begin errors++; $display("FAIL idle_cycle_count: got %0d expected 5", qi.cycle_count); end
        checks++; if (qi.empty !== 1'b1) begin errors++; $display("FAIL idle_empty: got %0b expected 1", qi.empty); end
        checks++; if (qi.occupancy !== 5'd0) begin errors++; $display("FAIL idle_occupancy: got %0d expected 0", qi.occupancy); end
        checks++; if (qi.out_op !== NOP) begin errors++; $display("FAIL idle_out_op: got %0d expected NOP", qi.out_op); end
        // Put something in the queue, then assert reset between edges.
        qi.in_op = DATA_READ; qi.in_address = 32'h0000_0BEE;
        step();
        qi.in_op = NOP;
        step();
        checks++; if (qi.occupancy !== 5'd1) begin errors++; $display("FAIL pre_async_occupancy: got %0d expected 1", qi.occupancy); end
        #3 reset_n = 1'b0;
        #1;
        checks++; if (qi.cycle_count !== 64'd0) begin errors++; $display("FAIL async_cycle_count: got %0d expected 0", qi.cycle_count); end
        checks++; if (qi.empty !== 1'b1) begin errors++; $display("FAIL async_empty: got %0b expected 1", qi.empty); end
        checks++; if (qi.occupancy !== 5'd0) begin errors++; $display("FAIL async_occupancy: got %0d expected 0", qi.occupancy); end
        checks++; if (qi.out_address !== 32'd0) begin errors++; $display("FAIL async_out_address: got %0h expected 0", qi.out_address); end
        checks++; if (qi.out_valid !== 1'b0) begin errors++; $display("FAIL async_out_valid: got %0b expected 0", qi.out_valid); end
        #2 reset_n = 1'b1;
    endtask

    task automatic test_single_push();
        do_reset();
        repeat (3) step();
        checks++; if (qi.cycle_count !== 64'd3) begin errors++; $display("FAIL sp_cycle_count: got %0d expected 3", qi.cycle_count); end
        qi.in_op = DATA_WRITE; qi.in_address = 32'h0000_1A40;
        step();
        qi.in_op = NOP; qi.in_address = '0;
        checks++; if (qi.out_valid !== 1'b1) begin errors++; $display("FAIL sp_out_valid: got %0b expected 1", qi.out_valid); end
        checks++; if (qi.out_op !== DATA_WRITE) begin errors++; $display("FAIL sp_out_op: got %0d expected DATA_WRITE", qi.out_op); end
        checks++; if (qi.out_address !== 32'h0000_1A40) begin errors++; $display("FAIL sp_out_address: got %0h expected 1a40", qi.out_address); end
        checks++; if (qi.out_enq_time !== 64'd3) begin errors++; $display("FAIL sp_enq_time: got %0d expected 3", qi.out_enq_time); end
        checks++; if (qi.out_age !== 64'd1) begin errors++; $display("FAIL sp_age1: got %0d expected 1", qi.out_age); end
        checks++; if (qi.occupancy !== 5'd1) begin errors++; $display("FAIL sp_occupancy: got %0d expected 1", qi.occupancy); end
        repeat (10) step();
        checks++; if (qi.out_age !== 64'd11) begin errors++; $display("FAIL sp_age11: got %0d expected 11", qi.out_age); end
    endtask

    task automatic test_fill_to_full();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            qi.in_op = DATA_READ; qi.in_address = 32'(i);
            step();
        end
        checks++; if (qi.full !== 1'b1) begin errors++; $display("FAIL fill_full: got %0b expected 1", qi.full); end
        checks++; if (qi.in_ready !== 1'b0) begin errors++; $display("FAIL fill_in_ready: got %0b expected 0", qi.in_ready); end
        checks++; if (qi.occupancy !== 5'd16) begin errors++; $display("FAIL fill_occupancy: got %0d expected 16", qi.occupancy); end
        qi.in_op = OPCODE_FETCH; qi.in_address = 32'hFFFF_FFFC;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (qi.occupancy !== 5'd16) begin errors++; $display("FAIL held_occupancy[%0d]: got %0d expected 16", i, qi.occupancy); end
        end
        checks++; if (qi.out_address !== 32'd1) begin errors++; $display("FAIL held_head: got %0h expected 1", qi.out_address); end
        // Offer and pop together while full: only the pop takes effect.
        qi.out_pop = 1'b1;
        step();
        qi.out_pop = 1'b0;
        checks++; if (qi.occupancy !== 5'd15) begin errors++; $display("FAIL fullpop_occupancy: got %0d expected 15", qi.occupancy); end
        checks++; if (qi.in_ready !== 1'b1) begin errors++; $display("FAIL fullpop_in_ready: got %0b expected 1", qi.in_ready); end
        checks++; if (qi.out_address !== 32'd2) begin errors++; $display("FAIL fullpop_head: got %0h expected 2", qi.out_address); end
        step();
        qi.in_op = NOP; qi.in_address = '0;
        checks++; if (qi.occupancy !== 5'd16) begin errors++; $display("FAIL held_accept_occupancy: got %0d expected 16", qi.occupancy); end
        qi.out_pop = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            checks++; if (qi.out_address !== 32'(i)) begin errors++; $display("FAIL drain_addr[%0d]: got %0h expected %0h", i, qi.out_address, i); end
            step();
        end
        checks++; if (qi.out_address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL drain_last_addr: got %0h expected fffffffc", qi.out_address); end
        checks++; if (qi.out_op !== OPCODE_FETCH) begin errors++; $display("FAIL drain_last_op: got %0d expected OPCODE_FETCH", qi.out_op); end
        step();
        qi.out_pop = 1'b0;
        checks++; if (qi.empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %0b expected 1", qi.empty); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            qi.in_op = DATA_WRITE; qi.in_address = 32'h100 + 32'(i);
            step();
        end
        checks++; if (qi.occupancy !== 5'd4) begin errors++; $display("FAIL b2b_start_occupancy: got %0d expected 4", qi.occupancy); end
        for (int k = 0; k < 8; k++) begin
            qi.in_op = DATA_READ; qi.in_address = 32'h104 + 32'(k); qi.out_pop = 1'b1;
            checks++; if (qi.out_address !== 32'h100 + 32'(k)) begin errors++; $display("FAIL b2b_head[%0d]: got %0h expected %0h", k, qi.out_address, 32'h100 + 32'(k)); end
            step();
            checks++; if (qi.occupancy !== 5'd4) begin errors++; $display("FAIL b2b_occupancy[%0d]: got %0d expected 4", k, qi.occupancy); end
        end
        qi.in_op = NOP;
        for (int k = 0; k < 4; k++) begin
            checks++; if (qi.out_address !== 32'h108 + 32'(k)) begin errors++; $display("FAIL b2b_drain[%0d]: got %0h expected %0h", k, qi.out_address, 32'h108 + 32'(k)); end
            step();
        end
        qi.out_pop = 1'b0;
        checks++; if (qi.empty !== 1'b1) begin errors++; $display("FAIL b2b_empty: got %0b expected 1", qi.empty); end
    endtask

    task automatic test_empty_pop_and_nop();
        do_reset();
        qi.out_pop = 1'b1;
        repeat (2) step();
        checks++; if (qi.occupancy !== 5'd0) begin errors++; $display("FAIL ep_occupancy: got %0d expected 0", qi.occupancy); end
        checks++; if (qi.out_valid !== 1'b0) begin errors++; $display("FAIL ep_out_valid: got %0b expected 0", qi.out_valid); end
        // Push while still popping an empty queue: the pop is ignored.
        qi.in_op = DATA_WRITE; qi.in_address = 32'h0000_0055;
        step();
        qi.in_op = NOP; qi.out_pop = 1'b0;
        checks++; if (qi.occupancy !== 5'd1) begin errors++; $display("FAIL ep_push_occupancy: got %0d expected 1", qi.occupancy); end
        checks++; if (qi.out_address !== 32'h0000_0055) begin errors++; $display("FAIL ep_push_head: got %0h expected 55", qi.out_address); end
        qi.in_address = 32'h0000_0077;
        step();
        checks++; if (qi.occupancy !== 5'd1) begin errors++; $display("FAIL nop_occupancy: got %0d expected 1", qi.occupancy); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        repeat (250) step();
        checks++; if (wi.cycle_count !== 8'd250) begin errors++; $display("FAIL wrap_start_count: got %0d expected 250", wi.cycle_count); end
        wi.in_op = DATA_READ; wi.in_address = 32'h0000_0ABC;
        step();
        wi.in_op = NOP;
        repeat (9) step();
        checks++; if (wi.cycle_count !== 8'd4) begin errors++; $display("FAIL wrap_count: got %0d expected 4", wi.cycle_count); end
        checks++; if (wi.out_enq_time !== 8'd250) begin errors++; $display("FAIL wrap_enq_time: got %0d expected 250", wi.out_enq_time); end
        checks++; if (wi.out_age !== 8'd10) begin errors++; $display("FAIL wrap_age: got %0d expected 10", wi.out_age); end
    endtask

    initial begin
        qi.in_op = NOP; qi.in_address = '0; qi.out_pop = 1'b0;
        wi.in_op = NOP; wi.in_address = '0; wi.out_pop = 1'b0;
        test_reset();
        test_single_push();
        test_fill_to_full();
        test_back_to_back();
        test_empty_pop_and_nop();
        test_counter_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_request_queue.md
# mem_request_queue

Consumer end of the parser output interface. Accepts parsed trace operations (opcode + address) from the parser and timestamps each one with an internal cycle counter. Buffers them in a DEPTH-entry in-order queue and presents the oldest entry to the downstream DRAM scheduler through a valid/pop handshake. Back-pressures the parser with `in_ready`, so the parser holds its current operation until the queue has room.

## Interface
- `ADDRESS_WIDTH`, 32, address bus width; same value as `global_defs::ADDRESS_WIDTH`.
- `DEPTH`, 16, queue entries; a power of two, ≥ 2.
- `TIME_WIDTH`, 64, width of the cycle counter and timestamps.
- `clock`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous reset, active-low.
- `in_op`  in  `parsed_op_t`  operation from the parser; `NOP` means no operation is offered.
- `in_address`  in  ADDRESS_WIDTH  address paired with `in_op`.
- `in_ready`  out  1  queue can accept an operation this cycle.
- `out_valid`  out  1  head entry is valid.
- `out_op`  out  `parsed_op_t`  head opcode; `NOP` when empty.
- `out_address`  out  ADDRESS_WIDTH  head address; 0 when empty.
- `out_enq_time`  out  TIME_WIDTH  cycle-counter value captured when the head entry was accepted; 0 when empty.
- `out_age`  out  TIME_WIDTH  `cycle_count − out_enq_time`, modulo 2^TIME_WIDTH; 0 when empty.
- `out_pop`  in  1  scheduler consumes the head entry this cycle.
- `occupancy`  out  $clog2(DEPTH)+1  number of valid entries.
- `full`  out  1  `occupancy == DEPTH`.
- `empty`  out  1  `occupancy == 0`.
- `cycle_count`  out  TIME_WIDTH  free-running cycle counter.

## Operation
- **Reset.** While `reset_n` = 0, regardless of the clock:
  - `cycle_count` = 0, head pointer = 0, tail pointer = 0, `occupancy` = 0.
  - `empty` = 1, `full` = 0, `in_ready` = 1, `out_valid` = 0.
  - `out_op` = `NOP`; `out_address`, `out_enq_time` and `out_age` = 0.
  - Entry storage does not need clearing.
- **Cycle counter.** `cycle_count` increments by 1 every clock edge after reset and wraps from 2^TIME_WIDTH−1 to 0.
- **Push condition.** A push occurs when `in_op` != `NOP` and `in_ready` = 1. The entry written at the tail holds `{in_op, in_address, cycle_count}`, where `cycle_count` is the pre-edge value. The tail pointer then advances modulo DEPTH.
- **Ready.** `in_ready` = `!full` and is computed from registered occupancy only. It does not depend on `out_pop` in the same cycle, so a full queue rejects an offer even while it is popping.
- **Rejected offers.** A non-`NOP` `in_op` offered while `in_ready` = 0 is not stored and nothing is dropped. The parser keeps presenting the same operation until it sees `in_ready` = 1.
- **Pop condition.** A pop occurs when `out_pop` = 1 and `out_valid` = 1; the head pointer advances modulo DEPTH. `out_pop` while empty is ignored, with no pointer or occupancy change.
- **Occupancy update per edge:**
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, with both pointers advancing
  - neither: unchanged
- **Head outputs.** `out_valid` = `!empty`. `out_op`, `out_address` and `out_enq_time` are read from the head entry and forced to `NOP`/0/0 when empty. `out_age` is a combinational subtraction in TIME_WIDTH-bit modulo arithmetic, so it stays correct across counter wrap.
- **Ordering.** Strictly first-in first-out. Opcode type does not affect ordering.
- **Reset mid-operation.** All entries are discarded. Any operation offered in the reset cycle is lost, and the parser re-offers it after reset.

## Timing
- **Enqueue-to-visible latency is 1 cycle.** An operation accepted at edge t appears at the head at t+1 if the queue was empty, with `out_enq_time` = the counter value before edge t and `out_age` = 1.
- **Pop effect.** Pop at edge t: the next entry, or the empty state, is visible after edge t.
- **Full.** `full` asserts the cycle after the push that brings occupancy to DEPTH. `in_ready` deasserts in that same cycle and reasserts the cycle after the first pop.
- **Output types.** All flags and the head outputs are functions of registered state only, with no combinational path from inputs. `out_age` is the one exception: it is combinational from registered `cycle_count` and head state.
- **Throughput.** Sustained one push and one pop per cycle whenever the queue is neither empty nor full.

## Test plan
- **Reset, then idle.** Release `reset_n`, drive `in_op` = `NOP` for 5 cycles → `empty` = 1, `occupancy` = 0, `out_op` = `NOP`, `cycle_count` = 5; an async assert mid-cycle zeroes all of them immediately.
- **Single push.** At `cycle_count` = 3, push `DATA_WRITE` with address 0x0000_1A40 → next cycle `out_valid` = 1, `out_op` = `DATA_WRITE`, `out_address` = 0x1A40, `out_enq_time` = 3, `out_age` = 1; 10 cycles later `out_age` = 11.
- **Fill to full.** Push 16 distinct addresses with no pops → `full` = 1 and `in_ready` = 0. A 17th offer of `OPCODE_FETCH` with address 0xFFFF_FFFC, held for 3 cycles, is not stored. One pop → `in_ready` = 1 the next cycle, the held op is accepted, and drain order is addresses 1..16 then 0xFFFF_FFFC.
- **Simultaneous push and pop.** At occupancy 4, push and pop together for 8 cycles → occupancy stays 4 and outputs appear in exact FIFO order. When full, push and pop together → only the pop occurs and occupancy drops to 15.
- **Empty pop and NOP.** `out_pop` = 1 while empty → no change, with pointers still equal. `in_op` = `NOP` with `in_ready` = 1 → no push.
- **Counter wrap.** Run with TIME_WIDTH = 8; push when `cycle_count` = 250 and hold the entry → when `cycle_count` = 4, `out_age` = 10.
